// File: rtl/atan2_sched_pkg.sv
// -----------------------------------------------------------------------------
// atan2_sched_pkg
// Shared types for the atan2 request scheduler:
//   ch_state_e : per-channel state (IDLE, BUSY, DONE)
//   tag_t      : result-routing tag (valid + channel index) carried alongside
//                the operands through the fixed-latency core
//   wrap_inc   : modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package atan2_sched_pkg;

   // The tag index is sized for the largest legal channel count (8), so the
   // struct is fixed-width no matter how the scheduler is parameterised.
   localparam int MAX_CHANNELS = 8;
   localparam int IDX_W        = $clog2(MAX_CHANNELS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } ch_state_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/atan2_tag_pipe.sv
// -----------------------------------------------------------------------------
// atan2_tag_pipe
// DEPTH-stage shift register carrying a result-routing tag in lock-step with
// the operands travelling through the external atan2 core.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low clear (drops every tag in flight)
//   tag_i : tag issued this cycle
//   tag_o : tag leaving the last stage
// -----------------------------------------------------------------------------
module atan2_tag_pipe
   import atan2_sched_pkg::*;
#(
   parameter int DEPTH = 26
) (
   input  logic clk,
   input  logic reset,
   input  tag_t tag_i,
   output tag_t tag_o
);

   logic             valid_q [DEPTH];
   logic [IDX_W-1:0] idx_q   [DEPTH];

   // NOTE: only the valid bits are cleared; the index payload is meaningless
   // while its valid bit is low, so the wide shift array needs no reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < DEPTH; s++) valid_q[s] <= 1'b0;
      end else begin
         valid_q[0] <= tag_i.valid;
         for (int s = 1; s < DEPTH; s++) valid_q[s] <= valid_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      idx_q[0] <= tag_i.idx;
      for (int s = 1; s < DEPTH; s++) idx_q[s] <= idx_q[s-1];
   end

   assign tag_o.valid = valid_q[DEPTH-1];
   assign tag_o.idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/atan2_sched.sv
// -----------------------------------------------------------------------------
// atan2_sched
// Round-robin scheduler sharing one fixed-latency atan2 core between CHANNELS
// requesters. Each channel has at most one operation in flight; its result is
// held in a per-channel register until consumed.
// Ports:
//   clk, reset               : clock, synchronous active-low reset
//   sink_valid/ready/x/y     : per-channel request handshake and operands
//   core_x, core_y           : registered operands to the shared core
//   core_res                 : core result, DELAY cycles after the operands
//   source_valid/ready       : per-channel result handshake
//   source                   : per-channel held result
//   busy                     : some channel has an operation in the core
// -----------------------------------------------------------------------------
module atan2_sched
   import atan2_sched_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DELAY    = 25,
   parameter int CHANNELS = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic        [CHANNELS-1:0]            sink_valid,
   output logic        [CHANNELS-1:0]            sink_ready,
   input  logic signed [CHANNELS-1:0][WIDTH-1:0] sink_x,
   input  logic signed [CHANNELS-1:0][WIDTH-1:0] sink_y,
   output logic signed [WIDTH-1:0]               core_x,
   output logic signed [WIDTH-1:0]               core_y,
   input  logic signed [WIDTH-1:0]               core_res,
   output logic        [CHANNELS-1:0]            source_valid,
   input  logic        [CHANNELS-1:0]            source_ready,
   output logic signed [CHANNELS-1:0][WIDTH-1:0] source,
   output logic                                  busy
);

   localparam int PTR_W = $clog2(CHANNELS);

   ch_state_e                      state_q [CHANNELS];
   logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic signed [WIDTH-1:0]        core_x_q, core_x_d;
   logic signed [WIDTH-1:0]        core_y_q, core_y_d;
   logic [CHANNELS-1:0][WIDTH-1:0] source_q;

   logic [CHANNELS-1:0] eligible;
   logic [CHANNELS-1:0] busy_vec;
   logic                grant_vld;
   logic [PTR_W-1:0]    grant_idx;
   logic [PTR_W-1:0]    cand_idx;
   int                  cand;
   logic                accept;
   tag_t                tag_issue;
   tag_t                tag_ret;

   // Per-channel status decode straight from the state registers.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         eligible[i]     = sink_valid[i] && (state_q[i] == IDLE);
         busy_vec[i]     = (state_q[i] == BUSY);
         source_valid[i] = (state_q[i] == DONE);
      end
   end

   // Round-robin search: first eligible channel at or after rr_ptr, wrapping.
   // NOTE: every variable gets a default before the loop so no latch is
   // inferred, and blocking '=' lets later iterations see the earlier hit.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= CHANNELS) cand = cand - CHANNELS;
         cand_idx = PTR_W'(cand);
         if (!grant_vld && eligible[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // Nothing is offered while reset is asserted.
   assign accept = reset && grant_vld;

   always_comb begin
      sink_ready = '0;
      if (accept) sink_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      core_x_d = '0;
      core_y_d = '0;
      if (accept) begin
         rr_ptr_d = PTR_W'(wrap_inc(int'(grant_idx), CHANNELS));
         core_x_d = sink_x[grant_idx];
         core_y_d = sink_y[grant_idx];
      end
   end

   assign tag_issue.valid = accept;
   assign tag_issue.idx   = IDX_W'(grant_idx);

   // DELAY+1 stages: the tag leaves the pipe in the same cycle core_res
   // presents the result of the operands loaded alongside it.
   atan2_tag_pipe #(
      .DEPTH (DELAY + 1)
   ) u_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .tag_i (tag_issue),
      .tag_o (tag_ret)
   );

   // Channel FSMs, round-robin pointer, core operand registers, result slots.
   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i]  <= IDLE;
            source_q[i] <= '0;
         end
         rr_ptr_q <= '0;
         core_x_q <= '0;
         core_y_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         core_x_q <= core_x_d;
         core_y_q <= core_y_d;
         for (int i = 0; i < CHANNELS; i++) begin
            unique case (state_q[i])
               IDLE: begin
                  if (accept && (grant_idx == PTR_W'(i))) state_q[i] <= BUSY;
               end
               BUSY: begin
                  if (tag_ret.valid && (tag_ret.idx == IDX_W'(i))) begin
                     state_q[i]  <= DONE;
                     source_q[i] <= core_res;
                  end
               end
               DONE: begin
                  // Grant decode only looks at IDLE, so a channel released
                  // here is first offered on the following cycle.
                  if (source_ready[i]) state_q[i] <= IDLE;
               end
               default: state_q[i] <= IDLE;
            endcase
         end
      end
   end

   assign core_x = core_x_q;
   assign core_y = core_y_q;
   assign source = source_q;
   assign busy   = |busy_vec;

endmodule

// File: tb/tb_atan2_sched.sv
// -----------------------------------------------------------------------------
// tb_atan2_sched
// Self-checking bench for atan2_sched (WIDTH=16, DELAY=25, CHANNELS=4) with a
// behavioural atan2 core attached. A per-channel reference model (state plus a
// countdown to result arrival) predicts every output each cycle; directed
// vectors and sequences add constant expectations for the corner cases.
// Angle scaling of the core: pi/2 -> 16384, clamped to the 16-bit range.
// -----------------------------------------------------------------------------
module tb_atan2_sched;

   localparam int WIDTH    = 16;
   localparam int DELAY    = 25;
   localparam int CHANNELS = 4;
   localparam real PI      = 3.14159265358979323846;

   localparam int M_IDLE = 0;
   localparam int M_BUSY = 1;
   localparam int M_DONE = 2;

   logic                                  clk = 1'b0;
   logic                                  reset;
   logic        [CHANNELS-1:0]            sink_valid;
   logic        [CHANNELS-1:0]            sink_ready;
   logic signed [CHANNELS-1:0][WIDTH-1:0] sink_x;
   logic signed [CHANNELS-1:0][WIDTH-1:0] sink_y;
   logic signed [WIDTH-1:0]               core_x;
   logic signed [WIDTH-1:0]               core_y;
   logic signed [WIDTH-1:0]               core_res;
   logic        [CHANNELS-1:0]            source_valid;
   logic        [CHANNELS-1:0]            source_ready;
   logic signed [CHANNELS-1:0][WIDTH-1:0] source;
   logic                                  busy;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   atan2_sched #(
      .WIDTH    (WIDTH),
      .DELAY    (DELAY),
      .CHANNELS (CHANNELS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_x       (sink_x),
      .sink_y       (sink_y),
      .core_x       (core_x),
      .core_y       (core_y),
      .core_res     (core_res),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source       (source),
      .busy         (busy)
   );

   // ---------------- behavioural atan2 core ----------------
   function automatic int atan2_ref(input int x, input int y);
      real a;
      int  r;
      a = $atan2(real'(y), real'(x)) * 32768.0 / PI;
      r = int'(a);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   logic signed [WIDTH-1:0] core_pipe [DELAY];
   always @(posedge clk) begin
      core_pipe[0] <= WIDTH'(atan2_ref(int'(core_x), int'(core_y)));
      for (int s = 1; s < DELAY; s++) core_pipe[s] <= core_pipe[s-1];
   end
   assign core_res = core_pipe[DELAY-1];

   // ---------------- reference model ----------------
   int m_state [CHANNELS];
   int m_cnt   [CHANNELS];
   int m_res   [CHANNELS];
   int m_src   [CHANNELS];
   int m_rr;
   int m_cx, m_cy;

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++) begin
         m_state[c] = M_IDLE;
         m_cnt[c]   = 0;
         m_res[c]   = 0;
         m_src[c]   = 0;
      end
      m_rr = 0;
      m_cx = 0;
      m_cy = 0;
   endtask

   function automatic int model_grant();
      if (!reset) return -1;
      for (int k = 0; k < CHANNELS; k++) begin
         int c;
         c = (m_rr + k) % CHANNELS;
         if (sink_valid[c] && m_state[c] == M_IDLE) return c;
      end
      return -1;
   endfunction

   task automatic model_check();
      int g;
      int any_busy;
      g = model_grant();
      any_busy = 0;
      check("sink_ready", int'(sink_ready), (g < 0) ? 0 : (1 << g));
      check("core_x", int'(core_x), m_cx);
      check("core_y", int'(core_y), m_cy);
      for (int c = 0; c < CHANNELS; c++) begin
         check("source_valid", int'(source_valid[c]), int'(m_state[c] == M_DONE));
         check("source", int'($signed(source[c])), m_src[c]);
         if (m_state[c] == M_BUSY) any_busy = 1;
      end
      check("busy", int'(busy), any_busy);
   endtask

   task automatic model_update();
      int g;
      g = model_grant();
      if (!reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         if (m_state[c] == M_BUSY) begin
            m_cnt[c]--;
            if (m_cnt[c] == 0) begin
               m_state[c] = M_DONE;
               m_src[c]   = m_res[c];
            end
         end else if (m_state[c] == M_DONE && source_ready[c]) begin
            m_state[c] = M_IDLE;
         end
      end
      if (g >= 0) begin
         m_state[g] = M_BUSY;
         m_cnt[g]   = DELAY + 1;
         m_res[g]   = atan2_ref(int'($signed(sink_x[g])), int'($signed(sink_y[g])));
         m_rr       = (g + 1) % CHANNELS;
         m_cx       = int'($signed(sink_x[g]));
         m_cy       = int'($signed(sink_y[g]));
      end else begin
         m_cx = 0;
         m_cy = 0;
      end
   endtask

   // One clock: compare at the falling edge, advance the model with the DUT.
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic randomize_operands();
      for (int c = 0; c < CHANNELS; c++) begin
         sink_x[c] = WIDTH'($urandom);
         sink_y[c] = WIDTH'($urandom);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int ch;
      int x;
      int y;
      int exp;
   } vec_t;

   localparam int NVEC = 5;
   vec_t vecs [NVEC];

   initial begin
      int n_other;

      vecs[0] = '{ch: 0, x:  16384, y:      0, exp:      0};
      vecs[1] = '{ch: 2, x:      0, y:  16384, exp:  16384};
      vecs[2] = '{ch: 1, x: -16384, y:      0, exp:  32767};
      vecs[3] = '{ch: 3, x:      0, y: -16384, exp: -16384};
      vecs[4] = '{ch: 1, x:  16384, y:  16384, exp:   8192};

      reset        = 1'b0;
      sink_valid   = '1;
      source_ready = '0;
      sink_x       = '0;
      sink_y       = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check("rst_sink_ready", int'(sink_ready), 0);
      check("rst_source_valid", int'(source_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_core_x", int'(core_x), 0);
      check("rst_core_y", int'(core_y), 0);
      for (int c = 0; c < CHANNELS; c++) check("rst_source", int'($signed(source[c])), 0);
      sink_valid = '0;
      reset      = 1'b1;
      step();

      // Single-channel transactions: latency, value, hold and release.
      for (int v = 0; v < NVEC; v++) begin
         int ch;
         ch = vecs[v].ch;
         sink_valid     = '0;
         sink_valid[ch] = 1'b1;
         sink_x[ch]     = WIDTH'(vecs[v].x);
         sink_y[ch]     = WIDTH'(vecs[v].y);
         #1;
         check("vec_grant", int'(sink_ready), 1 << ch);
         step();                        // acceptance edge t
         sink_valid = '0;
         repeat (DELAY) step();         // up to edge t+DELAY
         check("vec_early", int'(source_valid[ch]), 0);
         step();                        // edge t+DELAY+1: visible at edge t+DELAY+2
         check("vec_valid", int'(source_valid[ch]), 1);
         check("vec_result", int'($signed(source[ch])), vecs[v].exp);
         repeat (3) step();
         check("vec_hold_valid", int'(source_valid[ch]), 1);
         check("vec_hold_result", int'($signed(source[ch])), vecs[v].exp);
         source_ready[ch] = 1'b1;
         step();
         source_ready = '0;
         check("vec_released", int'(source_valid[ch]), 0);
         check("vec_kept", int'($signed(source[ch])), vecs[v].exp);
      end

      // Channel leaving DONE is not re-granted in the same cycle.
      sink_valid = 4'b0001;
      randomize_operands();
      step();
      sink_valid = '0;
      repeat (DELAY + 1) step();
      check("c42_done", int'(source_valid[0]), 1);
      sink_valid      = 4'b0001;
      source_ready[0] = 1'b1;
      #1;
      check("c42_same_cycle", int'(sink_ready[0]), 0);
      step();
      source_ready = '0;
      check("c42_next_cycle", int'(sink_ready[0]), 1);
      step();
      sink_valid = '0;
      source_ready = '1;
      repeat (DELAY + 4) step();
      source_ready = '0;

      // Ch1 held in DONE blocks only ch1.
      sink_valid = 4'b0010;
      randomize_operands();
      step();
      sink_valid = '0;
      repeat (DELAY + 1) step();
      sink_valid   = 4'b1111;
      source_ready = 4'b1101;
      n_other = 0;
      for (int k = 0; k < 40; k++) begin
         randomize_operands();
         #1;
         check("c40_ch1_blocked", int'(sink_ready[1]), 0);
         if (sink_ready != '0) n_other++;
         step();
      end
      check("c40_others_granted", int'(n_other >= 3), 1);
      check("c40_ch1_still_held", int'(source_valid[1]), 1);
      sink_valid   = '0;
      source_ready = '1;
      repeat (DELAY + 5) step();

      // All channels continuously valid from rr_ptr=0: rotation 0,1,2,3.
      reset = 1'b0;
      step();
      reset = 1'b1;
      sink_valid   = '1;
      source_ready = '1;
      for (int k = 0; k < CHANNELS; k++) begin
         randomize_operands();
         #1;
         check("c39_rotation", int'(sink_ready), 1 << k);
         step();
      end
      for (int k = 0; k < 80; k++) begin
         randomize_operands();
         step();
      end
      sink_valid = '0;
      repeat (DELAY + 5) step();

      // Reset with ch3 in flight: its stale result must never land.
      sink_valid = 4'b1000;
      randomize_operands();
      #1;
      check("c41_grant3", int'(sink_ready), 4'b1000);
      step();
      sink_valid = 4'b0001;             // move rr_ptr off 0 before reset
      step();
      sink_valid = '0;
      repeat (9) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < DELAY + 5; k++) begin
         step();
         check("c41_no_valid3", int'(source_valid[3]), 0);
         check("c41_source3", int'($signed(source[3])), 0);
      end
      sink_valid = '1;
      #1;
      check("c41_rr_restart", int'(sink_ready), 4'b0001);
      step();
      sink_valid = '0;
      repeat (DELAY + 5) step();

      // Randomized traffic against the model, with occasional resets.
      for (int k = 0; k < 500; k++) begin
         sink_valid   = CHANNELS'($urandom);
         source_ready = CHANNELS'($urandom);
         reset        = ($urandom_range(0, 149) != 0);
         randomize_operands();
         step();
      end
      reset        = 1'b1;
      sink_valid   = '0;
      source_ready = '1;
      repeat (DELAY + 5) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/atan2_sched.md
ATAN2_SCHED -- requirements
Module: atan2_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample and result width in bits.
REQ-002 SHALL have parameter DELAY, default 25, fixed latency in cycles of the attached atan2 core.
REQ-003 SHALL have parameter CHANNELS, default 4, number of requesters; legal range 2..8.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port sink_valid, input, CHANNELS, per-channel request valid.
REQ-007 SHALL have port sink_ready, output, CHANNELS, per-channel request accepted this cycle.
REQ-008 SHALL have port sink_x, input, CHANNELS x WIDTH signed, per-channel x operand.
REQ-009 SHALL have port sink_y, input, CHANNELS x WIDTH signed, per-channel y operand.
REQ-010 SHALL have port core_x, output, WIDTH signed, registered x to the shared atan2 core.
REQ-011 SHALL have port core_y, output, WIDTH signed, registered y to the shared atan2 core.
REQ-012 SHALL have port core_res, input, WIDTH signed, core result, DELAY cycles after core_x/core_y.
REQ-013 SHALL have port source_valid, output, CHANNELS, per-channel result held.
REQ-014 SHALL have port source_ready, input, CHANNELS, per-channel result consumed.
REQ-015 SHALL have port source, output, CHANNELS x WIDTH signed, per-channel result register.
REQ-016 SHALL have port busy, output, 1, high while any channel is BUSY.

Function
REQ-017 Each channel SHALL hold a state: IDLE, BUSY (operands in core), DONE (result held).
REQ-018 Channel i SHALL be eligible when sink_valid[i]=1 and state[i]=IDLE.
REQ-019 At most one channel SHALL be granted per cycle: the first eligible channel at or after rr_ptr, searching upward modulo CHANNELS.
REQ-020 sink_ready[i] SHALL be 1 only for the granted channel; acceptance = sink_valid[i] & sink_ready[i]; IDLE->BUSY on acceptance.
REQ-021 On acceptance, rr_ptr SHALL become (granted index + 1) mod CHANNELS; otherwise it holds.
REQ-022 On acceptance, core_x/core_y SHALL load sink_x/sink_y of the granted channel at the same edge; with no acceptance they SHALL load 0.
REQ-023 A tag (valid bit + channel index) SHALL be issued with each acceptance and delayed DELAY+1 cycles.
REQ-024 When a delayed tag emerges valid, source[tag] SHALL load core_res, and state[tag] SHALL go BUSY->DONE.
REQ-025 Latency: acceptance at edge t SHALL give source_valid high from edge t+DELAY+2; one result per cycle sustained when channels rotate.
REQ-026 source_valid[i] SHALL equal (state[i]=DONE); DONE->IDLE when source_ready[i]=1.
REQ-027 A channel leaving DONE SHALL NOT be granted in the same cycle; it becomes eligible the next cycle.
REQ-028 source[i] SHALL hold its value until overwritten by a new result for channel i.
REQ-029 Results SHALL never be dropped: each channel has at most one operation outstanding, so the held slot is free when a result returns.
REQ-030 Arithmetic SHALL be pass-through only; no truncation or sign change on any data path.

Reset
REQ-031 With reset=0 at an edge: all states IDLE, rr_ptr=0, tag valids 0, core_x=core_y=0, source=0, busy=0.
REQ-032 sink_ready SHALL be all-zero while reset=0.
REQ-033 Operations in flight at reset SHALL be discarded; stale core_res values SHALL never reach source.

Structure
REQ-034 Package atan2_sched_pkg SHALL hold the channel-state enum (IDLE, BUSY, DONE) and the tag struct (valid, index of width clog2(CHANNELS)).
REQ-035 Sub-module atan2_tag_pipe SHALL implement the DELAY+1-stage tag shift register with synchronous active-low clear.
REQ-036 The atan2 core SHALL be instantiated outside this block and connected via core_x, core_y, core_res.

Verification (bench attaches atan2 core, WIDTH=16, DELAY=25, CHANNELS=4)
REQ-037 Ch0 sends x=16384,y=0 -> source[0]=0 with source_valid[0] at acceptance+27 cycles.
REQ-038 Ch2 sends x=0,y=16384 -> source[2]=16384; held until source_ready[2]=1, then source_valid[2]=0.
REQ-039 All four channels valid continuously, all source_ready=1 -> grants 0,1,2,3,0... one per cycle, each result matches the reference model.
REQ-040 Ch1 DONE with source_ready[1]=0 while sink_valid[1]=1 -> sink_ready[1] stays 0 and other channels keep being granted.
REQ-041 Reset pulsed 10 cycles after ch3 acceptance -> source_valid[3] never rises, source[3]=0, rr_ptr restarts at 0.
REQ-042 Ch0 in DONE with source_ready[0]=1 and sink_valid[0]=1 in the same cycle -> sink_ready[0]=0 that cycle, 1 the next cycle.
